// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one radix-2 step per cycle, with fast paths
// for divide-by-zero and signed overflow, flush support and a one-cycle registered result pulse.
module ex_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic [REG_AW-1:0] reg_waddr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic [REG_AW-1:0] reg_waddr_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [REG_AW-1:0]   reg_waddr_q, reg_waddr_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                is_div_s, sgn1_s, sgn2_s, neg1_s, neg2_s, op2_zero_s, div_ovf_s;
  logic [XLEN-1:0]     abs1_s, abs2_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN+1:0]     div_trial_s;
  logic [2*XLEN-1:0]   step_s, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, calc_result_s;

  // Operand decode and magnitude conversion for the issuing operation.
  always_comb begin
    is_div_s   = op_i[2];
    sgn1_s     = is_div_s ? ~op_i[0] : ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10));
    sgn2_s     = is_div_s ? ~op_i[0] : (op_i[1:0] == 2'b01);
    neg1_s     = sgn1_s & op1_i[XLEN-1];
    neg2_s     = sgn2_s & op2_i[XLEN-1];
    abs1_s     = neg1_s ? -op1_i : op1_i;
    abs2_s     = neg2_s ? -op2_i : op2_i;
    op2_zero_s = (op2_i == {XLEN{1'b0}});
    div_ovf_s  = is_div_s && !op_i[0] && (op1_i == MIN_NEG) && (op2_i == {XLEN{1'b1}});
  end

  // One radix-2 step: acc holds {hi, multiplier} for mul, {remainder, dividend} for div.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_trial_s = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {2'b00, opb_q};
    if (op_q[2]) begin
      if (div_trial_s[XLEN+1]) begin
        step_s = {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
        step_s = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end else begin
      step_s = {mul_sum_s, acc_q[XLEN-1:1]};
    end
    prod_s = neg_res_q ? -step_s : step_s;
    quo_s  = neg_res_q ? -step_s[XLEN-1:0] : step_s[XLEN-1:0];
    rem_s  = neg_rem_q ? -step_s[2*XLEN-1:XLEN] : step_s[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      calc_result_s = op_q[1] ? rem_s : quo_s;
    end else begin
      calc_result_s = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic for the IDLE/CALC/DONE controller and its datapath registers.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    reg_waddr_d = reg_waddr_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = op_i;
          waddr_d = reg_waddr_i;
          if (is_div_s && (op2_zero_s || div_ovf_s)) begin
            state_d     = S_DONE;
            valid_d     = 1'b1;
            reg_waddr_d = reg_waddr_i;
            if (op2_zero_s) begin
              result_d = op_i[1] ? op1_i : {XLEN{1'b1}};
            end else begin
              result_d = op_i[1] ? {XLEN{1'b0}} : op1_i;
            end
          end else begin
            state_d   = S_CALC;
            count_d   = CW'(XLEN-1);
            acc_d     = {{XLEN{1'b0}}, (is_div_s ? abs1_s : abs2_s)};
            opb_d     = is_div_s ? abs2_s : abs1_s;
            neg_res_d = neg1_s ^ neg2_s;
            neg_rem_d = neg1_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_s;
          if (count_q == {CW{1'b0}}) begin
            state_d     = S_DONE;
            valid_d     = 1'b1;
            result_d    = calc_result_s;
            reg_waddr_d = waddr_q;
          end else begin
            count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      count_q     <= {CW{1'b0}};
      op_q        <= 3'b000;
      waddr_q     <= {REG_AW{1'b0}};
      reg_waddr_q <= {REG_AW{1'b0}};
      acc_q       <= {(2*XLEN){1'b0}};
      opb_q       <= {XLEN{1'b0}};
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      waddr_q     <= waddr_d;
      reg_waddr_q <= reg_waddr_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign reg_waddr_o = reg_waddr_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, fast paths, flush/busy/reset
// behaviour and randomized ops against an arithmetic reference model, plus an XLEN=64 instance.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  wa = 5'd0;
  logic        flush = 1'b0;
  logic        busy, valid;
  logic [31:0] res;
  logic [4:0]  wa_o;

  logic        start64 = 1'b0;
  logic [63:0] a64 = 64'd0;
  logic [63:0] b64 = 64'd0;
  logic        flush64 = 1'b0;
  logic        busy64, valid64;
  logic [63:0] res64;
  logic [4:0]  wa64_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .op1_i(a), .op2_i(b),
    .reg_waddr_i(wa), .flush_i(flush), .busy_o(busy), .valid_o(valid),
    .result_o(res), .reg_waddr_o(wa_o));

  ex_muldiv_unit #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .op_i(3'd0), .op1_i(a64), .op2_i(b64),
    .reg_waddr_i(5'd10), .flush_i(flush64), .busy_o(busy64), .valid_o(valid64),
    .result_o(res64), .reg_waddr_o(wa64_o));

  // Reference RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    logic [63:0]     p;
    logic            ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: p = ux * uy;
      3'd1: p = 64'(sx * sy) >> 32;
      3'd2: p = 64'(sx * longint'(uy)) >> 32;
      3'd3: p = (ux * uy) >> 32;
      3'd4: p = (y == 32'd0) ? 64'hFFFF_FFFF : (ovf ? 64'(x) : 64'(sx / sy));
      3'd5: p = (y == 32'd0) ? 64'hFFFF_FFFF : (ux / uy);
      3'd6: p = (y == 32'd0) ? 64'(x) : (ovf ? 64'd0 : 64'(sx % sy));
      default: p = (y == 32'd0) ? 64'(x) : (ux % uy);
    endcase
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Issue one op once idle and count edges from acceptance until valid_o; -1 if it never comes.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] w, output int lat);
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op = f; a = x; b = y; wa = w; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (valid) begin lat = i; break; end
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] w);
    int          lat;
    logic [31:0] exp = ref32(f, x, y);
    int          exp_lat = ref_lat(f, x, y);
    run_op(f, x, y, w, lat);
    n_cmp++;
    if (res !== exp) begin
      n_fail++;
      $display("FAIL %s result op=%0d a=%h b=%h: got %h want %h", name, f, x, y, res, exp);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency op=%0d: got %0d want %0d", name, f, lat, exp_lat);
    end
    n_cmp++;
    if (wa_o !== w) begin
      n_fail++;
      $display("FAIL %s waddr: got %0d want %0d", name, wa_o, w);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, valid, res, wa_o} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got busy=%b valid=%b res=%h wa=%0d want all 0", busy, valid, res, wa_o);
    end
  endtask

  task automatic test_directed;
    check_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd10);
    check_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    check_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2);
    check_op("mulhsu", 3'd2, 32'h8000_0000, 32'h8000_0000, 5'd3);
    check_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    check_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    check_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check_op("remu", 3'd7, 32'hFFFF_FFF9, 32'd2, 5'd7);
  endtask

  task automatic test_fast_path;
    check_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd8);
    check_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd9);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    check_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f = 3'($urandom_range(0, 7));
      logic [31:0] x = $urandom;
      logic [31:0] y = $urandom;
      int          sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 9));
      else if (sel == 3) x = -x;
      else y = y;
      check_op("random", f, x, y, 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_flush;
    logic [31:0] old_res = res;
    logic [4:0]  old_wa = wa_o;
    int          seen = 0;
    op = 3'd0; a = 32'd123; b = 32'd456; wa = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (valid) seen++;
    n_cmp++;
    if (busy !== 1'b0 || seen != 0) begin
      n_fail++;
      $display("FAIL flush_calc: busy=%b valid_pulses=%0d want busy=0 pulses=0", busy, seen);
    end
    n_cmp++;
    if (res !== old_res || wa_o !== old_wa) begin
      n_fail++;
      $display("FAIL flush_hold: res=%h wa=%0d want res=%h wa=%0d", res, wa_o, old_res, old_wa);
    end
    check_op("after_flush", 3'd0, 32'd3, 32'd4, 5'd21);
  endtask

  task automatic test_start_with_flush;
    @(posedge clk); #1;
    op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush: busy=%b valid=%b want 0 0", busy, valid);
    end
    // Fast-path op with flush too: must not produce a pulse either.
    op = 3'd5; a = 32'd1; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush_fast: busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  task automatic test_back_to_back;
    int lat = -1;
    logic [31:0] exp = ref32(3'd4, 32'd1000, 32'hFFFF_FFF9);
    op = 3'd4; a = 32'd1000; b = 32'hFFFF_FFF9; wa = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    op = 3'd0; a = 32'd2; b = 32'd2; wa = 5'd3; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 7; i <= 100; i++) begin
      @(posedge clk); #1;
      if (valid) begin lat = i; break; end
    end
    n_cmp++;
    if (res !== exp || wa_o !== 5'd17 || lat != 33) begin
      n_fail++;
      $display("FAIL start_busy: res=%h wa=%0d lat=%0d want res=%h wa=17 lat=33", res, wa_o, lat, exp);
    end
    flush = 1'b1;
    n_cmp++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_pulse: valid=%b want 1", valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0 || res !== exp) begin
      n_fail++;
      $display("FAIL flush_done_after: valid=%b busy=%b res=%h want 0 0 %h", valid, busy, res, exp);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; wa = 5'd30; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, valid, res, wa_o} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b valid=%b res=%h wa=%0d want all 0", busy, valid, res, wa_o);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_xlen64;
    int lat = -1;
    a64 = 64'd7; b64 = 64'hFFFF_FFFF_FFFF_FFFD; start64 = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      start64 = 1'b0;
      if (valid64) begin lat = i; break; end
    end
    n_cmp++;
    if (res64 !== 64'hFFFF_FFFF_FFFF_FFEB || lat != 65 || wa64_o !== 5'd10) begin
      n_fail++;
      $display("FAIL mul64: res=%h lat=%0d wa=%0d want FFFFFFFFFFFFFFEB 65 10", res64, lat, wa64_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fast_path();
    test_random();
    test_flush();
    test_start_with_flush();
    test_back_to_back();
    test_reset_mid();
    test_xlen64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
